// File: rtl/powermanager_pkg.sv
// Shared types and defaults for the powermanager rail sequencer.
//   pm_state_t : sequencer state encoding, also exported through STATUS.
//   PM_*_DEF   : default parameter values for the sequencer top.
package powermanager_pkg;

    localparam int unsigned PM_STATE_W         = 3;
    localparam int unsigned PM_NUM_RAILS_DEF   = 4;
    localparam int unsigned PM_TIMER_W_DEF     = 24;
    localparam int unsigned PM_SYNC_STAGES_DEF = 2;

    typedef enum logic [PM_STATE_W-1:0] {
        StOff   = 3'd0,
        StUpPg  = 3'd1,
        StUpDly = 3'd2,
        StOn    = 3'd3,
        StDown  = 3'd4,
        StFault = 3'd5
    } pm_state_t;

endpackage

// File: rtl/pm_sync_vec.sv
// Multi-bit flop synchronizer for independent asynchronous level inputs.
// Each bit passes through STAGES flops; all flops reset to 0.
//   i_clk  : destination clock
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous input vector
//   o_q    : synchronized vector
module pm_sync_vec #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < int'(STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/powermanager_rail_seq.sv
// Power-rail sequencer: enables rails in ascending order, each gated by its
// power-good, and disables them in reverse order. Power-good timeout or loss
// forces an all-off FAULT state that must be cleared with ctrl_on low.
//   i_clk / i_rst       : clock, synchronous active-high reset
//   i_ctrl_on           : 1 = power up, 0 = power down
//   i_ctrl_clr_fault    : one-cycle fault clear pulse
//   i_cfg_step_dly      : settle delay between rails (cycles)
//   i_cfg_pg_timeout    : max cycles to wait for a rail's power-good
//   i_pg_in             : asynchronous power-good pins
//   o_rail_en           : registered rail enables
//   o_stat_state        : current state encoding
//   o_stat_pg           : synchronized power-good
//   o_power_ok          : high only in ON
//   o_fault / o_fault_rail : sticky fault flag and offending rail index
module powermanager_rail_seq
    import powermanager_pkg::*;
#(
    parameter int unsigned NUM_RAILS   = PM_NUM_RAILS_DEF,
    parameter int unsigned TIMER_W     = PM_TIMER_W_DEF,
    parameter int unsigned SYNC_STAGES = PM_SYNC_STAGES_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_ctrl_on,
    input  logic                         i_ctrl_clr_fault,
    input  logic [TIMER_W-1:0]           i_cfg_step_dly,
    input  logic [TIMER_W-1:0]           i_cfg_pg_timeout,
    input  logic [NUM_RAILS-1:0]         i_pg_in,
    output logic [NUM_RAILS-1:0]         o_rail_en,
    output logic [PM_STATE_W-1:0]        o_stat_state,
    output logic [NUM_RAILS-1:0]         o_stat_pg,
    output logic                         o_power_ok,
    output logic                         o_fault,
    output logic [$clog2(NUM_RAILS)-1:0] o_fault_rail
);

    localparam int unsigned IDX_W = $clog2(NUM_RAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    pm_state_t              r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [TIMER_W-1:0]     r_timer;
    logic [TIMER_W-1:0]     r_step_cfg;
    logic [TIMER_W-1:0]     r_to_cfg;
    logic [NUM_RAILS-1:0]   r_rail_en;
    logic                   r_power_ok;
    logic                   r_fault;
    logic [IDX_W-1:0]       r_fault_rail;

    logic [NUM_RAILS-1:0]   w_pg_s;
    logic [NUM_RAILS-1:0]   w_low_up;
    logic [NUM_RAILS-1:0]   w_low_all;
    logic                   w_dly_done;

    pm_sync_vec #(
        .WIDTH  (NUM_RAILS),
        .STAGES (SYNC_STAGES)
    ) u_pg_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_pg_in),
        .o_q   (w_pg_s)
    );

    // Lowest set bit index; used to name the first rail that lost power-good.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_RAILS-1:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    always_comb begin
        w_low_all = ~w_pg_s;
        w_low_up  = '0;
        // Only rails already brought up (0..idx) must hold power-good.
        for (int i = 0; i < int'(NUM_RAILS); i++) begin
            w_low_up[i] = ~w_pg_s[i] & (i <= int'(r_idx));
        end
    end

    // A delay of D waits max(D,1) cycles: timer runs 0..D-1.
    assign w_dly_done = (r_step_cfg == '0) || (r_timer == r_step_cfg - TIMER_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StOff;
            r_idx        <= '0;
            r_timer      <= '0;
            r_step_cfg   <= '0;
            r_to_cfg     <= '0;
            r_rail_en    <= '0;
            r_power_ok   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
        end else begin
            case (r_state)
                StOff: begin
                    r_rail_en  <= '0;
                    r_power_ok <= 1'b0;
                    if (i_ctrl_on && !r_fault) begin
                        r_state    <= StUpPg;
                        r_idx      <= '0;
                        r_timer    <= '0;
                        r_step_cfg <= i_cfg_step_dly;
                        r_to_cfg   <= i_cfg_pg_timeout;
                    end
                end
                StUpPg: begin
                    // Rail 0 turns on here, one clock after leaving OFF; later
                    // rails are already set by the UP_DLY transition.
                    r_rail_en[r_idx] <= 1'b1;
                    if (w_pg_s[r_idx]) begin
                        r_state <= StUpDly;
                        r_timer <= '0;
                    end else if (r_timer == r_to_cfg) begin
                        r_state      <= StFault;
                        r_fault      <= 1'b1;
                        r_fault_rail <= r_idx;
                    end else if (!i_ctrl_on) begin
                        r_state          <= StDown;
                        r_timer          <= '0;
                        r_rail_en[r_idx] <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                StUpDly: begin
                    if (|w_low_up) begin
                        r_state      <= StFault;
                        r_fault      <= 1'b1;
                        r_fault_rail <= lowest_set(w_low_up);
                    end else if (!i_ctrl_on) begin
                        r_state          <= StDown;
                        r_timer          <= '0;
                        r_rail_en[r_idx] <= 1'b0;
                    end else if (w_dly_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= StOn;
                            r_power_ok <= 1'b1;
                        end else begin
                            r_state                          <= StUpPg;
                            r_timer                          <= '0;
                            r_idx                            <= r_idx + IDX_W'(1);
                            r_rail_en[r_idx + IDX_W'(1)]     <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                StOn: begin
                    if (|w_low_all) begin
                        r_state      <= StFault;
                        r_power_ok   <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_rail <= lowest_set(w_low_all);
                    end else if (!i_ctrl_on) begin
                        r_state             <= StDown;
                        r_power_ok          <= 1'b0;
                        r_timer             <= '0;
                        r_idx               <= LAST_IDX;
                        r_rail_en[LAST_IDX] <= 1'b0;
                    end
                end
                StDown: begin
                    // Each step clears its rail on entry, then waits the step delay.
                    if (w_dly_done) begin
                        r_timer <= '0;
                        if (r_idx == '0) begin
                            r_state <= StOff;
                        end else begin
                            r_idx                        <= r_idx - IDX_W'(1);
                            r_rail_en[r_idx - IDX_W'(1)] <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                StFault: begin
                    r_rail_en  <= '0;
                    r_power_ok <= 1'b0;
                    if (i_ctrl_clr_fault && !i_ctrl_on) begin
                        r_state <= StOff;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= StOff;
                    r_rail_en  <= '0;
                    r_power_ok <= 1'b0;
                end
            endcase
        end
    end

    assign o_rail_en    = r_rail_en;
    assign o_stat_state = r_state;
    assign o_stat_pg    = w_pg_s;
    assign o_power_ok   = r_power_ok;
    assign o_fault      = r_fault;
    assign o_fault_rail = r_fault_rail;

endmodule

// File: tb/tb_powermanager_rail_seq.sv
// Bench for powermanager_rail_seq (4 rails, 2 sync stages).
// Power-good is modelled as a per-rail latency after the rail enable rises;
// expected edge timings are derived from the sequencing rules as arithmetic.
module tb_powermanager_rail_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_on;
    logic        clr;
    logic [23:0] step;
    logic [23:0] tmo;
    logic [3:0]  pg_in;
    logic [3:0]  o_rail_en;
    logic [2:0]  o_stat_state;
    logic [3:0]  o_stat_pg;
    logic        o_power_ok;
    logic        o_fault;
    logic [1:0]  o_fault_rail;

    powermanager_rail_seq #(
        .NUM_RAILS   (4),
        .TIMER_W     (24),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ctrl_on        (ctrl_on),
        .i_ctrl_clr_fault (clr),
        .i_cfg_step_dly   (step),
        .i_cfg_pg_timeout (tmo),
        .i_pg_in          (pg_in),
        .o_rail_en        (o_rail_en),
        .o_stat_state     (o_stat_state),
        .o_stat_pg        (o_stat_pg),
        .o_power_ok       (o_power_ok),
        .o_fault          (o_fault),
        .o_fault_rail     (o_fault_rail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    int lat    [4];
    int cnt    [4];
    bit armed  [4];
    int rise   [4];
    int m_rise [4];
    int start;
    logic [3:0] prev_en;

    typedef struct {
        int d;
        int t;
        int l0, l1, l2, l3;
        int f;
        int rail;
        int endc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    // One clock: sample after the edge, then let the pg model react.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (o_rail_en[i] && !prev_en[i]) begin
                rise[i] = cyc - start;
                if (lat[i] == 0) pg_in[i] = 1'b1;
                else if (lat[i] != 255) begin
                    armed[i] = 1'b1;
                    cnt[i]   = lat[i];
                end
            end else if (armed[i]) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    pg_in[i] = 1'b1;
                    armed[i] = 1'b0;
                end
            end
        end
        prev_en = o_rail_en;
    endtask

    task automatic quiesce();
        ctrl_on = 1'b0;
        clr     = 1'b0;
        pg_in   = 4'b0;
        for (int i = 0; i < 4; i++) armed[i] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic begin_up(input int d, input int t, input int l0, input int l1,
                            input int l2, input int l3);
        step = 24'(d);
        tmo  = 24'(t);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        for (int i = 0; i < 4; i++) begin
            rise[i]  = -1;
            armed[i] = 1'b0;
        end
        pg_in   = 4'b0;
        prev_en = o_rail_en;
        start   = cyc;
        ctrl_on = 1'b1;
    endtask

    task automatic run_up(input int d, input int t, input int l0, input int l1,
                          input int l2, input int l3,
                          output int f, output int rl, output int en);
        bit done;
        begin_up(d, t, l0, l1, l2, l3);
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            if (o_stat_state == 3'd3 || o_stat_state == 3'd5) done = 1'b1;
        end
        chk("seq_terminates", int'(done), 1);
        f  = (o_stat_state == 3'd5) ? 1 : 0;
        rl = int'(o_fault_rail);
        en = cyc - start;
    endtask

    // Reference: rail i rises at E_i; its pg is seen L+3 edges later. UP_PG for
    // rail 0 starts one edge before E_0, so its timer budget is one edge shorter.
    task automatic predict(input int d, input int t, output int pf, output int pr,
                           output int pe);
        int m;
        int e;
        m  = (d == 0) ? 1 : d;
        e  = 2;
        pf = 0;
        pr = 0;
        for (int i = 0; i < 4; i++) m_rise[i] = -1;
        for (int i = 0; i < 4; i++) begin
            if (pf == 0) begin
                m_rise[i] = e;
                if (lat[i] == 255 || (i == 0 && lat[i] + 3 > t) ||
                    (i != 0 && lat[i] + 2 > t)) begin
                    pf = 1;
                    pr = i;
                    e  = (i == 0) ? e + t : e + t + 1;
                end else begin
                    e = e + lat[i] + 3 + m;
                end
            end
        end
        pe = e;
    endtask

    task automatic clear_fault(input int rail);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("clr_with_on_ignored", int'(o_stat_state), 5);
        ctrl_on = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_to_off_state", int'(o_stat_state), 0);
        chk("clr_fault_flag", int'(o_fault), 0);
        chk("clr_fault_rail_held", int'(o_fault_rail), rail);
    endtask

    // Post-sequence: check the fault outcome, or power down and time each rail.
    task automatic finish_seq(input int d, input int f, input int rail);
        int m;
        int fall [4];
        logic [3:0] pe;
        bit done;
        m = (d == 0) ? 1 : d;
        if (f != 0) begin
            tick();
            chk("fault_rails_off", int'(o_rail_en), 0);
            chk("fault_flag", int'(o_fault), 1);
            chk("fault_power_ok", int'(o_power_ok), 0);
            clear_fault(rail);
        end else begin
            chk("on_power_ok", int'(o_power_ok), 1);
            chk("on_rails", int'(o_rail_en), 15);
            for (int i = 0; i < 4; i++) fall[i] = -1;
            start   = cyc;
            ctrl_on = 1'b0;
            done    = 1'b0;
            for (int k = 0; k < 2000 && !done; k++) begin
                pe = o_rail_en;
                tick();
                for (int i = 0; i < 4; i++) begin
                    if (pe[i] && !o_rail_en[i]) fall[i] = cyc - start;
                end
                if (o_stat_state == 3'd0) done = 1'b1;
            end
            chk("down_terminates", int'(done), 1);
            for (int i = 0; i < 4; i++) chk($sformatf("down_fall_%0d", i), fall[i],
                                            1 + (3 - i) * m);
            chk("down_off_time", cyc - start, 1 + 4 * m);
            chk("down_no_fault", int'(o_fault), 0);
        end
        quiesce();
    endtask

    initial begin
        int f, rl, en;
        int pf, pr, pe;
        int d, t;
        bit hit;

        tbl[0] = '{10, 50, 4, 4, 4, 4,   0, 0, 70};
        tbl[1] = '{0,  0,  0, 0, 0, 0,   1, 0, 2};
        tbl[2] = '{1,  5,  2, 3, 3, 255, 1, 3, 28};
        tbl[3] = '{3,  10, 0, 9, 0, 0,   1, 1, 19};
        tbl[4] = '{2,  8,  5, 6, 1, 0,   0, 0, 34};
        tbl[5] = '{3,  10, 0, 8, 0, 0,   0, 0, 34};
        tbl[6] = '{0,  3,  0, 0, 0, 0,   0, 0, 18};

        rst = 1'b1; ctrl_on = 1'b0; clr = 1'b0; step = '0; tmo = '0; pg_in = '0;
        start = 0; prev_en = '0;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 255; cnt[i] = 0; armed[i] = 1'b0; rise[i] = -1;
        end
        pg_in = 4'b1111;
        repeat (3) tick();
        chk("rst_rail_en", int'(o_rail_en), 0);
        chk("rst_state", int'(o_stat_state), 0);
        chk("rst_stat_pg", int'(o_stat_pg), 0);
        chk("rst_power_ok", int'(o_power_ok), 0);
        chk("rst_fault", int'(o_fault), 0);
        chk("rst_fault_rail", int'(o_fault_rail), 0);
        pg_in = 4'b0;
        rst = 1'b0;
        repeat (3) tick();

        // Synchronizer latency: visible after exactly two edges.
        pg_in = 4'b1010;
        tick();
        chk("sync_stage1", int'(o_stat_pg), 0);
        tick();
        chk("sync_stage2", int'(o_stat_pg), 10);
        quiesce();

        for (int r = 0; r < 7; r++) begin
            run_up(tbl[r].d, tbl[r].t, tbl[r].l0, tbl[r].l1, tbl[r].l2, tbl[r].l3,
                   f, rl, en);
            chk($sformatf("tbl%0d_fault", r), f, tbl[r].f);
            chk($sformatf("tbl%0d_end", r), en, tbl[r].endc);
            if (tbl[r].f != 0) chk($sformatf("tbl%0d_rail", r), rl, tbl[r].rail);
            if (r == 0) begin
                chk("tbl0_rise1", rise[1], 19);
                chk("tbl0_rise3", rise[3], 53);
                chk("tbl0_state_on", int'(o_stat_state), 3);
            end
            finish_seq(tbl[r].d, f, tbl[r].rail);
        end

        // Power-good loss while ON.
        run_up(10, 50, 4, 4, 4, 4, f, rl, en);
        chk("loss_reached_on", f, 0);
        pg_in[1] = 1'b0;
        tick();
        tick();
        chk("loss_still_on", int'(o_stat_state), 3);
        tick();
        chk("loss_fault_state", int'(o_stat_state), 5);
        chk("loss_fault_rail", int'(o_fault_rail), 1);
        chk("loss_power_ok", int'(o_power_ok), 0);
        tick();
        chk("loss_rails_off", int'(o_rail_en), 0);
        clear_fault(1);
        quiesce();

        // ctrl_on drops during UP_DLY of rail 1; toggles in DOWN are ignored.
        begin_up(10, 50, 4, 4, 4, 4);
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            tick();
            if (o_rail_en == 4'b0011 && o_stat_state == 3'd2) hit = 1'b1;
        end
        chk("abort_reached_dly1", int'(hit), 1);
        ctrl_on = 1'b0;
        tick();
        chk("abort_down_state", int'(o_stat_state), 4);
        chk("abort_rail1_off", int'(o_rail_en), 1);
        ctrl_on = 1'b1;
        repeat (3) tick();
        ctrl_on = 1'b0;
        repeat (6) tick();
        chk("abort_rail0_held", int'(o_rail_en), 1);
        tick();
        chk("abort_rail0_off", int'(o_rail_en), 0);
        repeat (9) tick();
        chk("abort_still_down", int'(o_stat_state), 4);
        tick();
        chk("abort_off", int'(o_stat_state), 0);
        chk("abort_no_fault", int'(o_fault), 0);
        quiesce();

        // Reset in UP_PG of rail 2.
        begin_up(10, 50, 4, 4, 4, 4);
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            tick();
            if (o_rail_en == 4'b0111 && o_stat_state == 3'd1) hit = 1'b1;
        end
        chk("rstmid_reached", int'(hit), 1);
        rst = 1'b1;
        ctrl_on = 1'b0;
        tick();
        chk("rstmid_rails", int'(o_rail_en), 0);
        chk("rstmid_state", int'(o_stat_state), 0);
        chk("rstmid_fault", int'(o_fault), 0);
        rst = 1'b0;
        quiesce();

        // Randomized sequences against the timing model.
        for (int it = 0; it < 30; it++) begin
            d = int'($urandom_range(0, 4));
            t = int'($urandom_range(0, 14));
            for (int i = 0; i < 4; i++)
                lat[i] = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 10));
            predict(d, t, pf, pr, pe);
            run_up(d, t, lat[0], lat[1], lat[2], lat[3], f, rl, en);
            chk($sformatf("rnd%0d_fault", it), f, pf);
            chk($sformatf("rnd%0d_end", it), en, pe);
            if (pf != 0) chk($sformatf("rnd%0d_rail", it), rl, pr);
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_rise%0d", it, i), rise[i], m_rise[i]);
            finish_seq(d, f, pr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
